// File: rtl/pong_game_ctrl.sv
`timescale 1ns/1ps
// pong_game_ctrl
// Top-level Pong game sequencer in the pixel clock domain. Walks through the
// startup screen, serve delay, live play, point pause and game-over lockout.
// It owns both scores and drives the renderer/physics control signals.
//
// Ports:
//   clk_0        pixel clock
//   rst          synchronous, active-low reset
//   frame_tick   one-cycle pulse per frame (start of vertical blank)
//   any_key      level, OR of all player buttons
//   miss_left    one-cycle pulse, player 1 missed the ball
//   miss_right   one-cycle pulse, player 2 missed the ball
//   show_startup startup text enable
//   sq_shown     ball visible
//   play_en      ball/paddle physics enable
//   ball_reset   one-cycle pulse, re-centre the ball
//   serve_dir    0 = serve toward player 1, 1 = toward player 2
//   score_p1     player 1 score
//   score_p2     player 2 score
//   game_over    game-over indication
//
// All outputs come straight from flops; each is computed from the next state.
module pong_game_ctrl #(
  parameter int WIN_SCORE        = 11,
  parameter int SERVE_FRAMES     = 60,
  parameter int POINT_FRAMES     = 30,
  parameter int OVER_LOCK_FRAMES = 120
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       any_key,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       show_startup,
  output logic       sq_shown,
  output logic       play_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_GAME_OVER
  } state_t;

  // A timed exit fires on the tick that would take the count to N, so the
  // comparison is against N-1 while the tick is present.
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [7:0] OVER_LOCK  = 8'(OVER_LOCK_FRAMES);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     state_reg, state_next;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic       key_q_reg;
  logic [3:0] score_p1_reg, score_p1_next;
  logic [3:0] score_p2_reg, score_p2_next;
  logic       serve_dir_reg, serve_dir_next;
  logic       ball_reset_reg, ball_reset_next;
  logic       show_startup_reg, sq_shown_reg, play_en_reg, game_over_reg;
  logic       key_rise;
  logic [7:0] cnt_inc;

  // key_q resets to 1 so a key held through reset never looks like a press.
  assign key_rise = any_key & ~key_q_reg;
  assign cnt_inc  = frame_cnt_reg + 8'd1;

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state_reg        <= ST_STARTUP;
      frame_cnt_reg    <= 8'd0;
      key_q_reg        <= 1'b1;
      score_p1_reg     <= 4'd0;
      score_p2_reg     <= 4'd0;
      serve_dir_reg    <= 1'b1;
      ball_reset_reg   <= 1'b0;
      show_startup_reg <= 1'b1;
      sq_shown_reg     <= 1'b0;
      play_en_reg      <= 1'b0;
      game_over_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      frame_cnt_reg    <= frame_cnt_next;
      key_q_reg        <= any_key;
      score_p1_reg     <= score_p1_next;
      score_p2_reg     <= score_p2_next;
      serve_dir_reg    <= serve_dir_next;
      ball_reset_reg   <= ball_reset_next;
      show_startup_reg <= (state_next == ST_STARTUP);
      sq_shown_reg     <= (state_next == ST_SERVE) || (state_next == ST_PLAY);
      play_en_reg      <= (state_next == ST_PLAY);
      game_over_reg    <= (state_next == ST_GAME_OVER);
    end
  end

  always_comb begin
    state_next      = state_reg;
    frame_cnt_next  = frame_cnt_reg;
    score_p1_next   = score_p1_reg;
    score_p2_next   = score_p2_reg;
    serve_dir_next  = serve_dir_reg;
    ball_reset_next = 1'b0;

    case (state_reg)
      ST_STARTUP: begin
        if (key_rise) begin
          score_p1_next   = 4'd0;
          score_p2_next   = 4'd0;
          serve_dir_next  = 1'b1;
          ball_reset_next = 1'b1;
          state_next      = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt_reg == SERVE_LAST) begin
            state_next = ST_PLAY;
          end else begin
            frame_cnt_next = cnt_inc;
          end
        end
      end

      ST_PLAY: begin
        // Simultaneous misses replay the rally: no score, direction kept.
        if (miss_left && miss_right) begin
          state_next = ST_POINT;
        end else if (miss_left) begin
          score_p2_next  = score_p2_reg + 4'd1;
          serve_dir_next = 1'b0;
          state_next     = ST_POINT;
        end else if (miss_right) begin
          score_p1_next  = score_p1_reg + 4'd1;
          serve_dir_next = 1'b1;
          state_next     = ST_POINT;
        end
      end

      ST_POINT: begin
        if (frame_tick) begin
          if (frame_cnt_reg == POINT_LAST) begin
            if ((score_p1_reg == WIN) || (score_p2_reg == WIN)) begin
              state_next = ST_GAME_OVER;
            end else begin
              ball_reset_next = 1'b1;
              state_next      = ST_SERVE;
            end
          end else begin
            frame_cnt_next = cnt_inc;
          end
        end
      end

      ST_GAME_OVER: begin
        // Counter saturates at the lockout value; only then is a press taken.
        if (key_rise && (frame_cnt_reg == OVER_LOCK)) begin
          state_next = ST_STARTUP;
        end else if (frame_tick && (frame_cnt_reg != OVER_LOCK)) begin
          frame_cnt_next = cnt_inc;
        end
      end

      default: begin
        state_next = ST_STARTUP;
      end
    endcase

    // Every state entry starts its frame count from zero.
    if (state_next != state_reg) begin
      frame_cnt_next = 8'd0;
    end
  end

  assign show_startup = show_startup_reg;
  assign sq_shown     = sq_shown_reg;
  assign play_en      = play_en_reg;
  assign ball_reset   = ball_reset_reg;
  assign serve_dir    = serve_dir_reg;
  assign score_p1     = score_p1_reg;
  assign score_p2     = score_p2_reg;
  assign game_over    = game_over_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for pong_game_ctrl: directed scenarios followed by a
// long randomized run compared every cycle against a behavioural model.
module tb_pong_game_ctrl;

  localparam int WIN   = 11;
  localparam int SERVE = 60;
  localparam int POINT = 30;
  localparam int LOCK  = 120;

  // {show_startup, sq_shown, play_en, ball_reset, serve_dir, p1, p2, game_over}
  localparam logic [13:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0};

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       any_key = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       show_startup, sq_shown, play_en, ball_reset, serve_dir, game_over;
  logic [3:0] score_p1, score_p2;

  int checks = 0;
  int errors = 0;

  pong_game_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT), .OVER_LOCK_FRAMES(LOCK)
  ) dut (
    .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .any_key(any_key),
    .miss_left(miss_left), .miss_right(miss_right), .show_startup(show_startup),
    .sq_shown(sq_shown), .play_en(play_en), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over)
  );

  always #5 clk_0 = ~clk_0;

  logic [13:0] obs;
  assign obs = {show_startup, sq_shown, play_en, ball_reset, serve_dir,
                score_p1, score_p2, game_over};

  // Behavioural model: game phase plus ticks seen since the phase began.
  typedef enum {M_STARTUP, M_SERVE, M_PLAY, M_POINT, M_OVER} phase_t;
  phase_t m_phase = M_STARTUP;
  int     m_ticks = 0;
  int     m_p1 = 0, m_p2 = 0;
  bit     m_dir = 1'b1, m_brst = 1'b0, m_key_prev = 1'b1;

  task automatic enter(input phase_t p);
    m_phase = p;
    m_ticks = 0;
  endtask

  task automatic model_step(input bit r, input bit t, input bit k, input bit ml, input bit mr);
    bit pressed;
    if (!r) begin
      enter(M_STARTUP);
      m_p1 = 0; m_p2 = 0; m_dir = 1'b1; m_brst = 1'b0; m_key_prev = 1'b1;
      return;
    end
    pressed    = k && !m_key_prev;
    m_key_prev = k;
    m_brst     = 1'b0;
    case (m_phase)
      M_STARTUP: if (pressed) begin
        m_p1 = 0; m_p2 = 0; m_dir = 1'b1; m_brst = 1'b1;
        enter(M_SERVE);
      end
      M_SERVE: if (t) begin
        m_ticks++;
        if (m_ticks == SERVE) enter(M_PLAY);
      end
      M_PLAY: begin
        if (ml && mr) enter(M_POINT);
        else if (ml) begin m_p2++; m_dir = 1'b0; enter(M_POINT); end
        else if (mr) begin m_p1++; m_dir = 1'b1; enter(M_POINT); end
      end
      M_POINT: if (t) begin
        m_ticks++;
        if (m_ticks == POINT) begin
          if (m_p1 == WIN || m_p2 == WIN) enter(M_OVER);
          else begin m_brst = 1'b1; enter(M_SERVE); end
        end
      end
      M_OVER: begin
        if (pressed && m_ticks >= LOCK) enter(M_STARTUP);
        else if (t && m_ticks < LOCK) m_ticks++;
      end
      default: enter(M_STARTUP);
    endcase
  endtask

  function automatic logic [13:0] exp_vec();
    return {m_phase == M_STARTUP, m_phase == M_SERVE || m_phase == M_PLAY,
            m_phase == M_PLAY, m_brst, m_dir, 4'(m_p1), 4'(m_p2), m_phase == M_OVER};
  endfunction

  // One clock: drive inputs, advance DUT and model together, settle.
  task automatic cyc(input bit t, input bit k, input bit ml, input bit mr);
    frame_tick = t; any_key = k; miss_left = ml; miss_right = mr;
    @(posedge clk_0);
    model_step(rst, t, k, ml, mr);
    #1;
  endtask

  // n frame ticks with random idle gaps between them.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values got=%b want=%b", obs, RESET_VEC);
    end
    $display("test_reset done");
  endtask

  task automatic test_key_edge;
    rst = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL held_key_no_exit got=%b want=%b", obs, RESET_VEC);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({show_startup, ball_reset, sq_shown, play_en} !== 4'b0110) begin
      errors++;
      $display("FAIL press_to_serve got=%b want=0110",
               {show_startup, ball_reset, sq_shown, play_en});
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({ball_reset, sq_shown} !== 2'b01) begin
      errors++;
      $display("FAIL ball_reset_one_cycle got=%b want=01", {ball_reset, sq_shown});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    $display("test_key_edge done");
  endtask

  task automatic test_serve;
    run_ticks(SERVE - 1);
    checks++;
    if ({sq_shown, play_en} !== 2'b10) begin
      errors++;
      $display("FAIL serve_59_ticks got=%b want=10", {sq_shown, play_en});
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({sq_shown, play_en} !== 2'b11) begin
      errors++;
      $display("FAIL serve_60th_tick got=%b want=11", {sq_shown, play_en});
    end
    $display("test_serve done");
  endtask

  task automatic test_miss_left;
    repeat ($urandom_range(1, 6)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({score_p1, score_p2, serve_dir, sq_shown, play_en} !== {4'd0, 4'd1, 3'b000}) begin
      errors++;
      $display("FAIL miss_left_score got=%b want=%b",
               {score_p1, score_p2, serve_dir, sq_shown, play_en}, {4'd0, 4'd1, 3'b000});
    end
    run_ticks(POINT - 1);
    checks++;
    if ({ball_reset, sq_shown} !== 2'b00) begin
      errors++;
      $display("FAIL point_29_ticks got=%b want=00", {ball_reset, sq_shown});
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({ball_reset, sq_shown, play_en} !== 3'b110) begin
      errors++;
      $display("FAIL point_exit_serve got=%b want=110", {ball_reset, sq_shown, play_en});
    end
    run_ticks(SERVE);
    $display("test_miss_left done");
  endtask

  task automatic test_both_miss;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({score_p1, score_p2, serve_dir, sq_shown, play_en} !== {4'd0, 4'd1, 3'b000}) begin
      errors++;
      $display("FAIL both_miss got=%b want=%b",
               {score_p1, score_p2, serve_dir, sq_shown, play_en}, {4'd0, 4'd1, 3'b000});
    end
    $display("test_both_miss done");
  endtask

  task automatic test_game_over;
    for (int i = 1; i <= WIN; i++) begin
      run_ticks(POINT);
      run_ticks(SERVE);
      repeat ($urandom_range(0, 4)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({score_p1, serve_dir} !== {4'(i), 1'b1}) begin
        errors++;
        $display("FAIL miss_right_%0d got=%b want=%b", i, {score_p1, serve_dir}, {4'(i), 1'b1});
      end
    end
    run_ticks(POINT - 1);
    checks++;
    if (game_over !== 1'b0) begin
      errors++;
      $display("FAIL over_before_pause got=%b want=0", game_over);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({game_over, sq_shown, ball_reset, score_p1, score_p2} !== {3'b100, 4'd11, 4'd1}) begin
      errors++;
      $display("FAIL game_over_entry got=%b want=%b",
               {game_over, sq_shown, ball_reset, score_p1, score_p2}, {3'b100, 4'd11, 4'd1});
    end
    run_ticks(50);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({game_over, show_startup} !== 2'b10) begin
      errors++;
      $display("FAIL key_at_tick50 got=%b want=10", {game_over, show_startup});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    run_ticks(LOCK - 51);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({game_over, show_startup} !== 2'b10) begin
      errors++;
      $display("FAIL key_at_tick119 got=%b want=10", {game_over, show_startup});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    run_ticks(6);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({game_over, show_startup} !== 2'b01) begin
      errors++;
      $display("FAIL key_after_lock got=%b want=01", {game_over, show_startup});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    $display("test_game_over done");
  endtask

  task automatic test_reset_mid;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({score_p1, score_p2, ball_reset} !== {4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_clears got=%b want=%b", {score_p1, score_p2, ball_reset},
               {4'd0, 4'd0, 1'b1});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      run_ticks(SERVE);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      run_ticks(POINT);
    end
    run_ticks(SERVE);
    checks++;
    if ({score_p1, play_en} !== {4'd5, 1'b1}) begin
      errors++;
      $display("FAIL p1_five_in_play got=%b want=%b", {score_p1, play_en}, {4'd5, 1'b1});
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_mid_play got=%b want=%b", obs, RESET_VEC);
    end
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    $display("test_reset_mid done");
  endtask

  task automatic test_random;
    int bad = 0;
    bit k = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      rst = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 7) == 0) k = ~k;
      cyc($urandom_range(0, 1) == 0, k, $urandom_range(0, 19) == 0,
          $urandom_range(0, 19) == 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle_%0d got=%b want=%b", c, obs, exp_vec());
      end
    end
    rst = 1'b1;
    $display("test_random done");
  endtask

  initial begin
    test_reset;
    test_key_edge;
    test_serve;
    test_miss_left;
    test_both_miss;
    test_game_over;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Top-level game sequencer for Pong, clocked in the pixel domain.
- Steps through startup screen, serve delay, live play, point pause and game over.
- Owns both scores and drives the renderer's state inputs: sq_shown, score_p1, score_p2, game_over and the startup-text enable.
- Gates ball physics through play_en and requests ball re-centring through ball_reset.

Parameters:
- WIN_SCORE, 11, score that ends the game (must be ≤ 15).
- SERVE_FRAMES, 60, frame_tick pulses the ball sits visible and stationary before play.
- POINT_FRAMES, 30, frame_tick pulses the ball stays hidden after a point.
- OVER_LOCK_FRAMES, 120, frame_tick pulses after game over before a key is accepted.

Ports:
- clk_0  in  1  25.175 MHz pixel clock.
- rst  in  1  reset, synchronous, active-low.
- frame_tick  in  1  one-cycle pulse once per frame (start of vertical blank).
- any_key  in  1  level, OR of all player buttons.
- miss_left  in  1  one-cycle pulse: ball passed paddle1 (player 1 missed).
- miss_right  in  1  one-cycle pulse: ball passed paddle2 (player 2 missed).
- show_startup  out  1  startup text enable.
- sq_shown  out  1  ball visible.
- play_en  out  1  ball/paddle physics enabled.
- ball_reset  out  1  one-cycle pulse: re-centre ball.
- serve_dir  out  1  0 = serve toward player 1 (left), 1 = toward player 2 (right).
- score_p1  out  4  player 1 score.
- score_p2  out  4  player 2 score.
- game_over  out  1  game-over indication.

Behaviour:
- All outputs are registered. An output change appears the cycle after the input that triggers it.
- Reset (rst=0 at a clk_0 edge), from any state, mid-operation included:
  - state = STARTUP; scores = 0; show_startup = 1.
  - sq_shown, play_en, ball_reset, game_over = 0; serve_dir = 1.
  - frame counter = 0; key_q = 1.
- Key edge: key_rise = any_key & ~key_q, with key_q <= any_key every cycle. Because key_q resets to 1, a key held through reset never triggers.
- Frame counter:
  - 8-bit; cleared on every state entry.
  - Increments on frame_tick.
  - A timed exit fires on the frame_tick that takes the count to N, i.e. exactly N ticks after entry.
- States:
  - STARTUP: show_startup = 1, sq_shown = 0, play_en = 0. On key_rise: clear both scores, serve_dir = 1, pulse ball_reset, go to SERVE.
  - SERVE: sq_shown = 1, play_en = 0. After SERVE_FRAMES ticks, go to PLAY.
  - PLAY: sq_shown = 1, play_en = 1.
    - miss_left only: score_p2 + 1, serve_dir = 0, go to POINT.
    - miss_right only: score_p1 + 1, serve_dir = 1, go to POINT.
    - Both in the same cycle: no score change, serve_dir unchanged, go to POINT (replayed rally).
  - POINT: sq_shown = 0, play_en = 0. After POINT_FRAMES ticks:
    - if score_p1 == WIN_SCORE or score_p2 == WIN_SCORE, go to GAME_OVER;
    - otherwise pulse ball_reset and go to SERVE.
  - GAME_OVER: game_over = 1, sq_shown = 0, play_en = 0, scores held.
    - Once OVER_LOCK_FRAMES ticks have elapsed, key_rise goes to STARTUP (game_over = 0).
    - A key_rise before the lockout ends is discarded.
    - The counter saturates at OVER_LOCK_FRAMES.
- Ignored inputs:
  - miss_left / miss_right are ignored outside PLAY.
  - key_rise is ignored in SERVE, PLAY and POINT.
  - frame_tick is ignored in STARTUP.
- Scores:
  - 4-bit unsigned, increment only in PLAY.
  - They can never exceed WIN_SCORE, since the game ends first, so no wrap occurs.
- ball_reset is high for exactly one cycle per transition into SERVE and is 0 at all other times.

Test Plan:
- Reset with any_key held high, then release and press again -> no exit from STARTUP until the second rising edge. Then: show_startup = 0, ball_reset high for 1 cycle, sq_shown = 1, play_en = 0.
- From SERVE, issue 59 frame_ticks -> play_en stays 0. 60th tick -> play_en = 1 the next cycle.
- In PLAY, pulse miss_left -> score_p2 = 1, serve_dir = 0, sq_shown = 0. After 30 ticks -> ball_reset pulse, then SERVE.
- In PLAY, assert miss_left and miss_right together -> scores unchanged, POINT entered, serve_dir unchanged.
- Drive score_p1 to 11 via repeated miss_right -> game_over = 1 after the POINT pause. A key at tick 50 is ignored; a key after tick 120 -> STARTUP.
- Assert rst during PLAY with score_p1 = 5 -> next cycle all outputs at reset values, state STARTUP.
